// File: rtl/mem_dump_tx.sv
// Reads words from a synchronous-read memory and streams each one out as four
// 8N1 UART frames, least-significant byte first.
module mem_dump_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE, READ, LATCH, START_BIT, DATA_BITS, STOP_BIT, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [31:0]       shift_q, shift_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        bit_idx_d   = bit_idx_q;
        baud_d      = baud_q;
        mem_rd_en_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // tx is registered from the current state, so the line trails the
        // FSM by one cycle; this puts the first start bit three edges after start.
        case (state_q)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = shift_q[0];
            default:   tx_d = 1'b1;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
                    if (word_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = READ;
                        busy_d      = 1'b1;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = base_addr;
                    end
                end
            end
            READ: state_d = LATCH;
            LATCH: begin
                shift_d    = mem_rdata;
                byte_idx_d = 2'd0;
                baud_d     = '0;
                state_d    = START_BIT;
            end
            START_BIT: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA_BITS;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA_BITS: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP_BIT: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_idx_q == 2'd3) begin
                        remaining_d = remaining_q - REM_ONE;
                        addr_d      = addr_q + ADDR_ONE;
                        if (remaining_d != '0) begin
                            state_d     = READ;
                            mem_rd_en_d = 1'b1;
                            mem_addr_d  = addr_q + ADDR_ONE;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = START_BIT;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            bit_idx_q   <= '0;
            baud_q      <= '0;
            mem_rd_en_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            bit_idx_q   <= bit_idx_d;
            baud_q      <= baud_d;
            mem_rd_en_q <= mem_rd_en_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: memory model, UART decoder and a scoreboard fed by a
// word-level model of the dump (addresses and little-endian bytes per word).
module tb_mem_dump_tx;

    localparam int CPB    = 4;
    localparam int ADDR_W = 10;
    localparam int WORD_CYCLES = 2 + 40 * CPB;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic              tx;
    logic              busy;
    logic              done;
    logic [2:0]        dbg_state;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [7:0]        exp_byte_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tx_falls = 0;
    int first_fall_cyc = -1;
    int done_cnt = 0;
    int rst_cnt = 0;
    logic prev_tx = 1'b1;

    mem_dump_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .tx(tx), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];
    always @(negedge rst_n) rst_cnt = rst_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (prev_tx && !tx) begin
            tx_falls = tx_falls + 1;
            if (first_fall_cyc < 0) first_fall_cyc = cyc;
        end
        prev_tx = tx;
        if (mem_rd_en) begin
            if (exp_addr_q.size() == 0) check("rd_extra", 1, 0);
            else check("rd_addr", mem_addr, exp_addr_q.pop_front());
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            check("done_busy", busy, 0);
        end
    end

    // UART receiver: sample each bit near its centre on falling clock edges.
    logic [7:0] rx_byte;
    logic       start_ok, stop_ok;
    int         frame_rst;
    always begin
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            frame_rst = rst_cnt;
            repeat (CPB / 2) @(negedge clk);
            start_ok = (tx == 1'b0);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                rx_byte[k] = tx;
            end
            repeat (CPB) @(negedge clk);
            stop_ok = tx;
            if (frame_rst == rst_cnt) begin
                check("start_bit", start_ok, 1);
                check("stop_bit", stop_ok, 1);
                if (exp_byte_q.size() == 0) check("byte_extra", 1, 0);
                else check("byte", rx_byte, exp_byte_q.pop_front());
            end
        end
    end

    task automatic run_dump(input logic [ADDR_W-1:0] base, input int cnt,
                            input int glitch_at, input bit start_in_done);
        logic [ADDR_W-1:0] a;
        logic [31:0] w;
        int acc, n, falls0, dones0;
        for (int i = 0; i < cnt; i++) begin
            a = base + ADDR_W'(i);
            w = mem[a];
            exp_addr_q.push_back(a);
            for (int b = 0; b < 4; b++) exp_byte_q.push_back(w[8*b +: 8]);
        end
        first_fall_cyc = -1;
        falls0 = tx_falls;
        dones0 = done_cnt;
        base_addr = base;
        word_count = (ADDR_W + 1)'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        check("busy_acc", busy, cnt != 0);
        check("rd_lat", mem_rd_en, cnt != 0);
        n = 0;
        while (!done && n < WORD_CYCLES * cnt + 50) begin
            @(negedge clk);
            n++;
            if (glitch_at > 0) begin
                if (cyc == acc + glitch_at) begin
                    start = 1'b1;
                    base_addr = base + 10'd77;
                    word_count = 11'd3;
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!done) check("done_timeout", 0, 1);
        else check("done_lat", cyc - acc, WORD_CYCLES * cnt);
        if (start_in_done) begin
            start = 1'b1;
            base_addr = 10'd99;
            word_count = 11'd3;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", done, 0);
        check("done_cnt", done_cnt - dones0, 1);
        check("busy_end", busy, 0);
        if (cnt > 0) check("tx_lat", first_fall_cyc - acc, 3);
        else check("tx_quiet", tx_falls - falls0, 0);
        check("bytes_left", exp_byte_q.size(), 0);
        check("reads_left", exp_addr_q.size(), 0);
    endtask

    initial begin
        int acc, falls0, dones0;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        mem[0] = 32'h12345678;
        run_dump(10'd0, 1, 0, 1'b0);
        run_dump(10'd0, 0, 0, 1'b0);
        mem[1023] = 32'hAABBCCDD;
        mem[0] = 32'h01020304;
        run_dump(10'd1023, 2, 0, 1'b0);
        run_dump(10'd7, 1, 50, 1'b0);
        run_dump(10'd20, 1, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("ign_busy", busy, 0);

        // Abort a dump with reset while byte 1 is on the line.
        exp_addr_q.push_back(10'd5);
        for (int b = 0; b < 4; b++) exp_byte_q.push_back(mem[5][8*b +: 8]);
        base_addr = 10'd5;
        word_count = 11'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        while (cyc < acc + 54) @(negedge clk);
        check("pre_rst_bytes", exp_byte_q.size(), 3);
        rst_n = 1'b0;
        #1;
        check("arst_tx", tx, 1);
        check("arst_busy", busy, 0);
        check("arst_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_byte_q.delete();
        falls0 = tx_falls;
        dones0 = done_cnt;
        repeat (100) @(negedge clk);
        check("post_rst_falls", tx_falls - falls0, 0);
        check("post_rst_done", done_cnt - dones0, 0);
        check("post_rst_busy", busy, 0);

        run_dump(10'd30, 1, 0, 1'b0);
        run_dump(10'd31, 2, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            run_dump(ADDR_W'($urandom_range(0, 1023)), $urandom_range(1, 3),
                     ($urandom_range(0, 1) == 1) ? $urandom_range(5, 150) : 0, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1);
    end

endmodule
